// File: rtl/counter10k_scheduler_pkg.sv
// Shared definitions for the counter10k scheduler: FSM encoding, counter
// period and a small modular-add helper used by the arbiter and the FSM.
package counter10k_scheduler_pkg;

  // Ticks per counter10k period (reached pulses once per PERIOD run ticks)
  localparam int PERIOD = 10000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } state_e;

  // (a + b) mod n for a, b already in [0, n)
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/counter10k_scheduler_rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping past N_REQ-1 back to 0.
module counter10k_scheduler_rr_picker
  import counter10k_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] pos;

  // Scan outward from ptr; the first hit locks the result
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    pos    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = IDX_W'(wrap_add(int'(ptr), k, N_REQ));
      if (!any && req[pos]) begin
        any         = 1'b1;
        idx         = pos;
        onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter10k_scheduler.sv
// Shares one counter10k among N_REQ requesters. A round-robin winner gets the
// counter for dur x PERIOD ticks: one clear tick, then counting until the
// requested number of reached pulses has arrived, then a one-tick done pulse.
// Dropping req while owning the counter abandons the interval without done.
module counter10k_scheduler
  import counter10k_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DUR_W = 8,
  parameter int IDX_W = 2
) (
  input  logic                   tick,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DUR_W-1:0] dur,
  output logic [N_REQ-1:0]       grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [DUR_W-1:0]       periods_left,
  output logic                   run_counter,
  input  logic                   reached
);

  state_e                       state;
  logic [IDX_W-1:0]             rr_ptr;
  logic [IDX_W-1:0]             rr_after_owner;
  logic [N_REQ-1:0]             pick_oh;
  logic [IDX_W-1:0]             pick_idx;
  logic                         pick_any;
  logic                         owner_req;
  logic [N_REQ-1:0][DUR_W-1:0]  dur_a;

  // Lane i of dur_a is dur[i*DUR_W +: DUR_W]
  assign dur_a          = dur;
  // Owner still wants the counter; low means abort
  assign owner_req      = |(req & grant);
  assign rr_after_owner = IDX_W'(wrap_add(int'(grant_idx), 1, N_REQ));

  counter10k_scheduler_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Scheduler FSM: arbitration, interval bookkeeping and all registered outputs.
  // A zero-length request still passes through CLEAR so done lands one tick
  // after grant and the counter is never released.
  // Abort is tested before reached, so a simultaneous reached is discarded.
  always_ff @(posedge tick or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= '0;
      grant_idx    <= '0;
      done         <= '0;
      busy         <= 1'b0;
      periods_left <= '0;
      run_counter  <= 1'b0;
      rr_ptr       <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          run_counter <= 1'b0;
          if (pick_any) begin
            grant        <= pick_oh;
            grant_idx    <= pick_idx;
            busy         <= 1'b1;
            periods_left <= dur_a[pick_idx];
            state        <= CLEAR;
          end
        end

        CLEAR: begin
          if (!owner_req) begin
            grant       <= '0;
            busy        <= 1'b0;
            run_counter <= 1'b0;
            rr_ptr      <= rr_after_owner;
            state       <= IDLE;
          end else if (periods_left == '0) begin
            done  <= grant;
            state <= FINISH;
          end else begin
            run_counter <= 1'b1;
            state       <= RUN;
          end
        end

        RUN: begin
          if (!owner_req) begin
            grant       <= '0;
            busy        <= 1'b0;
            run_counter <= 1'b0;
            rr_ptr      <= rr_after_owner;
            state       <= IDLE;
          end else if (reached) begin
            periods_left <= periods_left - DUR_W'(1);
            if (periods_left == DUR_W'(1)) begin
              done        <= grant;
              run_counter <= 1'b0;
              state       <= FINISH;
            end
          end
        end

        FINISH: begin
          grant       <= '0;
          busy        <= 1'b0;
          run_counter <= 1'b0;
          rr_ptr      <= rr_after_owner;
          state       <= IDLE;
        end

        default: begin
          grant       <= '0;
          busy        <= 1'b0;
          run_counter <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter10k_scheduler.sv
// Bench for counter10k_scheduler with a behavioural counter10k attached.
// counter10k model: count clears while run is low, counts 0..PERIOD-1 while
// high, and registers a one-tick reached pulse after the count sat at PERIOD-1.
// The reference model predicts outputs from the grant time by arithmetic:
// done at grant+2+dur*PERIOD (grant+1 for dur 0), decrements every PERIOD.
module tb_counter10k_scheduler;
  import counter10k_scheduler_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            tick;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] dur;
  logic [N-1:0]    grant;
  logic [IW-1:0]   grant_idx;
  logic [N-1:0]    done;
  logic            busy;
  logic [DW-1:0]   periods_left;
  logic            run_counter;
  logic            reached;

  counter10k_scheduler #(.N_REQ(N), .DUR_W(DW), .IDX_W(IW)) dut (
    .tick         (tick),
    .reset        (reset),
    .req          (req),
    .dur          (dur),
    .grant        (grant),
    .grant_idx    (grant_idx),
    .done         (done),
    .busy         (busy),
    .periods_left (periods_left),
    .run_counter  (run_counter),
    .reached      (reached)
  );

  initial begin
    tick = 1'b0;
    forever #5 tick = ~tick;
  end

  // counter10k stand-in
  int cnt;
  always @(posedge tick or posedge reset) begin
    if (reset) begin
      cnt     <= 0;
      reached <= 1'b0;
    end else begin
      reached <= run_counter && (cnt == PERIOD - 1);
      if (!run_counter)          cnt <= 0;
      else if (cnt == PERIOD - 1) cnt <= 0;
      else                        cnt <= cnt + 1;
    end
  end

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model state
  int          m_owner = -1;
  int          m_g = 0, m_d = 0, m_D = 0, m_pl = 0, m_rr = 0;
  bit          m_fin = 0;
  logic [N-1:0] e_grant = '0, e_done = '0;
  logic        e_busy = 1'b0, e_run = 1'b0;
  int          e_idx = 0, e_pl = 0;

  always @(posedge tick or posedge reset) begin
    if (reset) begin
      m_owner = -1; m_fin = 0; m_pl = 0; m_rr = 0;
      e_done = '0; e_run = 1'b0;
    end else begin
      cyc++;
      e_done = '0;
      if (m_fin) begin
        m_fin = 0; m_owner = -1;
      end else if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_rr + k) % N;
          if (m_owner < 0 && req[j]) m_owner = j;
        end
        if (m_owner >= 0) begin
          m_g  = cyc;
          m_d  = int'(dur[m_owner*DW +: DW]);
          m_pl = m_d;
          m_D  = (m_d == 0) ? cyc + 1 : cyc + 2 + m_d * PERIOD;
        end
      end else begin
        if (!req[m_owner]) begin
          m_rr = (m_owner + 1) % N; m_owner = -1;
        end else if (cyc == m_D) begin
          m_fin = 1; m_pl = 0; e_done[m_owner] = 1'b1; m_rr = (m_owner + 1) % N;
        end else if (cyc > m_g + 2 && (cyc - m_g - 2) % PERIOD == 0) begin
          m_pl--;
        end
      end
      e_run = (m_owner >= 0) && !m_fin && (cyc > m_g);
    end
    e_busy  = (m_owner >= 0);
    e_grant = e_busy ? (N'(1) << m_owner) : '0;
    e_idx   = e_busy ? m_owner : 0;
    e_pl    = m_pl;
  end

  // Event log used by the directed checks
  int   ngrant = 0, last_gcyc = 0, last_gidx = 0;
  int   ndone_tot = 0, last_dcyc = 0, last_didx = 0;
  int   ndone[N] = '{default: 0};
  bit   run_seen = 0;
  logic busy_q = 1'b0;

  // Every-cycle compare against the model, plus event logging
  always @(negedge tick) begin
    if (!reset) begin
      chk("grant", 32'(grant), 32'(e_grant));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("run_counter", 32'(run_counter), 32'(e_run));
      chk("periods_left", 32'(periods_left), e_pl);
      if (e_busy) chk("grant_idx", 32'(grant_idx), e_idx);
      if (busy && !busy_q) begin
        ngrant++; last_gcyc = cyc; last_gidx = int'(grant_idx);
      end
      if (done != '0) begin
        ndone_tot++; last_dcyc = cyc;
        for (int i = 0; i < N; i++) if (done[i]) begin ndone[i]++; last_didx = i; end
      end
      if (run_counter) run_seen = 1;
    end
    busy_q = busy;
  end

  task automatic step();
    @(negedge tick);
    #1;
  endtask

  task automatic set_dur(input int i, input int v);
    dur[i*DW +: DW] = DW'(v);
  endtask

  task automatic wait_grant(input int limit);
    int k = 0;
    int start = ngrant;
    while (ngrant == start && k < limit) begin step(); k++; end
    chk("wait_grant_timeout", 32'(ngrant != start), 32'd1);
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    int start = ndone_tot;
    while (ndone_tot == start && k < limit) begin step(); k++; end
    chk("wait_done_timeout", 32'(ndone_tot != start), 32'd1);
  endtask

  int g, t, nd;

  initial begin
    reset = 1'b1;
    req   = '0;
    dur   = '0;
    repeat (3) step();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_run", 32'(run_counter), 32'd0);
    chk("rst_pl", 32'(periods_left), 32'd0);
    chk("rst_idx", 32'(grant_idx), 32'd0);
    reset = 1'b0;
    step();

    // Reset in the middle of a 3-period interval
    set_dur(0, 3);
    req = 4'b0001;
    wait_grant(4);
    g = last_gcyc;
    chk("s1_grant", 32'(grant), 32'h1);
    while (cyc < g + 15000) step();
    chk("s1_pl_mid", 32'(periods_left), 32'd2);
    reset = 1'b1;
    #1;
    chk("s1_rst_grant", 32'(grant), 32'd0);
    chk("s1_rst_busy", 32'(busy), 32'd0);
    chk("s1_rst_run", 32'(run_counter), 32'd0);
    chk("s1_rst_pl", 32'(periods_left), 32'd0);
    chk("s1_rst_done", 32'(done), 32'd0);
    chk("s1_no_done", 32'(ndone[0]), 32'd0);
    req = '0;
    step();
    reset = 1'b0;
    step();

    // All four request one period each; round robin from pointer 0
    for (int i = 0; i < N; i++) set_dur(i, 1);
    req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      wait_grant(12000);
      g = last_gcyc;
      chk("s3_order", 32'(last_gidx), 32'(i));
      if (i == 3) begin
        set_dur(3, 7);   // must not affect the running interval
        set_dur(0, 5);
        req[1] = 1'b0;
        req[2] = 1'b0;
      end
      wait_done(12000);
      chk("s3_latency", 32'(last_dcyc - g), 32'd10002);
      chk("s3_done_idx", 32'(last_didx), 32'(i));
    end

    // Fifth grant wraps to 0 (dur 5); abort it at 12000 with req[3] pending
    wait_grant(12000);
    g = last_gcyc;
    chk("s3_wrap", 32'(last_gidx), 32'd0);
    chk("s5_pl_grant", 32'(periods_left), 32'd5);
    while (cyc < g + 12000) step();
    chk("s5_pl_mid", 32'(periods_left), 32'd4);
    nd = ndone[0];
    set_dur(3, 2);
    req[0] = 1'b0;
    step();
    chk("s5_abort_busy", 32'(busy), 32'd0);
    step();
    chk("s5_grant3", 32'(grant), 32'h8);
    chk("s5_clear", 32'(run_counter), 32'd0);
    chk("s5_pl3", 32'(periods_left), 32'd2);
    chk("s5_no_done0", 32'(ndone[0]), 32'(nd));

    // Abort on the same tick reached is presented
    t = 0;
    while (!reached && t < 12000) begin step(); t++; end
    chk("s6_reached_seen", 32'(reached), 32'd1);
    nd = ndone[3];
    req[3] = 1'b0;
    step();
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_pl_kept", 32'(periods_left), 32'd2);
    chk("s6_no_done", 32'(ndone[3]), 32'(nd));
    step();

    // Single requester, two periods
    set_dur(1, 2);
    req = 4'b0010;
    t = cyc;
    wait_grant(4);
    g = last_gcyc;
    chk("s2_req_to_grant", 32'(g - t), 32'd1);
    chk("s2_grant", 32'(grant), 32'h2);
    wait_done(25000);
    chk("s2_latency", 32'(last_dcyc - g), 32'd20002);
    chk("s2_done_idx", 32'(last_didx), 32'd1);
    req = '0;
    step();
    step();

    // Zero-length interval never starts the counter
    set_dur(2, 0);
    run_seen = 0;
    req = 4'b0100;
    wait_grant(4);
    g = last_gcyc;
    chk("s4_grant", 32'(grant), 32'h4);
    wait_done(5);
    chk("s4_latency", 32'(last_dcyc - g), 32'd1);
    chk("s4_done_idx", 32'(last_didx), 32'd2);
    req = '0;
    step();
    step();
    chk("s4_no_run", 32'(run_seen), 32'd0);
    chk("s4_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
